// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and the
// first/last tag carried with each buffered word.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FLUSH
    } fifo_burst_reader_state_t;

    // Data width is a module parameter, so the payload travels beside this tag
    typedef struct packed {
        logic first;
        logic last;
    } fbr_tag_t;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry registered valid/ready buffer. Entry 0 is the head and drives the
// outputs directly, so nothing downstream sees a combinational path from push.
module fifo_burst_reader_skid
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_first_i,
    input  logic             push_last_i,
    output logic [1:0]       count_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_first_o,
    output logic             out_last_o
);
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    fbr_tag_t         tag0_q, tag0_d, tag1_q, tag1_d;
    fbr_tag_t         push_tag;
    logic [1:0]       count_q, count_d;
    logic             push_ok, pop;

    assign push_tag = '{first: push_first_i, last: push_last_i};

    always_comb begin
        push_ok = push_i && (count_q != 2'd2);
        pop     = (count_q != 2'd0) && out_ready_i;
        data0_d = data0_q;
        data1_d = data1_q;
        tag0_d  = tag0_q;
        tag1_d  = tag1_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b01: begin
                data0_d = data1_q;
                tag0_d  = tag1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    data0_d = push_data_i;
                    tag0_d  = push_tag;
                end else begin
                    data1_d = push_data_i;
                    tag1_d  = push_tag;
                end
                count_d = count_q + 2'd1;
            end
            // Simultaneous push and pop only happens with one entry held
            2'b11: begin
                data0_d = push_data_i;
                tag0_d  = push_tag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data0_q <= '0;
            data1_q <= '0;
            tag0_q  <= '0;
            tag1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = data0_q;
    assign out_first_o = tag0_q.first;
    assign out_last_o  = tag0_q.last;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for a show-ahead FIFO: drains full bursts, or partial
// content on flush request / idle timeout, onto a tagged valid/ready stream.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int BURST_LENGTH   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   fifo_read_enable,
    input  logic [WIDTH-1:0]       fifo_read_data,
    input  logic                   fifo_empty,
    input  logic [$clog2(DEPTH):0] fifo_level,
    input  logic                   flush_request,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   busy
);
    localparam int REM_W = $clog2(BURST_LENGTH + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(BURST_LENGTH);
    localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT_CYCLES - 1);

    fifo_burst_reader_state_t state_q;
    logic [REM_W-1:0]         remaining_q, initial_q;
    logic [TMR_W-1:0]         timer_q;
    logic [1:0]               buf_count;
    logic [31:0]              level_ext;
    logic                     burst_ready, level_nonzero, timeout_hit;
    logic                     pop_first, pop_last;

    assign level_ext     = 32'(fifo_level);
    assign burst_ready   = level_ext >= 32'(BURST_LENGTH);
    assign level_nonzero = level_ext != 32'd0;
    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_FIRE);

    // Depends only on registers and fifo_empty; out_ready never reaches it
    assign fifo_read_enable = (state_q != IDLE) && (remaining_q != '0)
                              && !fifo_empty && (buf_count != 2'd2);
    assign pop_first = (remaining_q == initial_q);
    assign pop_last  = (remaining_q == REM_W'(1));
    assign busy      = (state_q != IDLE) || (buf_count != 2'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            initial_q   <= '0;
            timer_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (burst_ready) begin
                        state_q     <= BURST;
                        remaining_q <= REM_FULL;
                        initial_q   <= REM_FULL;
                        timer_q     <= '0;
                    end else if (level_nonzero && (flush_request || timeout_hit)) begin
                        state_q     <= FLUSH;
                        remaining_q <= REM_W'(fifo_level);
                        initial_q   <= REM_W'(fifo_level);
                        timer_q     <= '0;
                    end else if ((TIMEOUT_CYCLES == 0) || !level_nonzero) begin
                        timer_q <= '0;
                    end else if (timer_q != TMR_SAT) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    timer_q <= '0;
                    if (fifo_read_enable) begin
                        remaining_q <= remaining_q - REM_W'(1);
                        if (pop_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    fifo_burst_reader_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk_i        (clock),
        .rst_i        (reset),
        .push_i       (fifo_read_enable),
        .push_data_i  (fifo_read_data),
        .push_first_i (pop_first),
        .push_last_i  (pop_last),
        .count_o      (buf_count),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_first_o  (out_first),
        .out_last_o   (out_last)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural show-ahead FIFO upstream, a
// scoreboard queue filled at write time and a monitor that checks each transfer.
module tb_fifo_burst_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int BL    = 4;
    localparam int TO    = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             rd_en;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_empty;
    logic [2:0]       fifo_level;
    logic             flush_request = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_first;
    logic             out_last;
    logic             busy;

    always #5 clock = ~clock;

    fifo_burst_reader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LENGTH(BL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .fifo_read_enable (rd_en),
        .fifo_read_data   (fifo_rdata),
        .fifo_empty       (fifo_empty),
        .fifo_level       (fifo_level),
        .flush_request    (flush_request),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_first        (out_first),
        .out_last         (out_last),
        .busy             (busy)
    );

    // Upstream FIFO model, reset together with the DUT
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0]       wp, rp;
    logic [2:0]       cnt;
    logic             do_rd, do_wr;

    assign do_rd      = rd_en && (cnt != 3'd0);
    assign do_wr      = wr_en && (cnt != 3'd4);
    assign fifo_rdata = mem[rp];
    assign fifo_empty = (cnt == 3'd0);
    assign fifo_level = cnt;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            wp  <= 2'd0;
            rp  <= 2'd0;
            cnt <= 3'd0;
        end else begin
            if (do_wr) begin
                mem[wp] <= wr_data;
                wp      <= wp + 2'd1;
            end
            if (do_rd) rp <= rp + 2'd1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: ;
            endcase
        end
    end

    int pops = 0;
    always @(posedge clock) if (!reset && rd_en) pops <= pops + 1;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             f;
        logic             l;
        logic             tags;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [WIDTH-1:0] d, input logic f, input logic l, input logic t);
        exp_t e;
        e.d = d; e.f = f; e.l = l; e.tags = t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: order/tag scoreboard, burst framing, and hold-under-backpressure
    exp_t             mon_e;
    logic             in_burst = 1'b0;
    int               blen = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_d;
    logic             prev_f, prev_l;

    always @(negedge clock) begin
        if (reset) begin
            in_burst   = 1'b0;
            blen       = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_word", {out_first, out_last, out_data}, {prev_f, prev_l, prev_d});
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", out_data);
                end else begin
                    mon_e = expq.pop_front();
                    chk("stream_data", out_data, mon_e.d);
                    if (mon_e.tags) chk("stream_tags", {out_first, out_last}, {mon_e.f, mon_e.l});
                end
                if (out_first) begin
                    chk("first_inside_burst", in_burst, 0);
                    in_burst = 1'b1;
                    blen     = 1;
                end else begin
                    chk("word_outside_burst", in_burst, 1);
                    blen++;
                end
                chk("burst_too_long", blen <= BL, 1);
                if (out_last) in_burst = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_f     = out_first;
            prev_l     = out_last;
        end
    end

    task automatic wr(input logic [WIDTH-1:0] d, input logic f, input logic l, input logic t);
        wr_en   = 1'b1;
        wr_data = d;
        expq.push_back(mk(d, f, l, t));
        @(posedge clock); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_request = 1'b1;
        @(posedge clock); #1;
        flush_request = 1'b0;
    endtask

    // Counts negedges with no pop until the first pop; ends on that negedge
    task automatic wait_rd(input int maxc, input string name, output int n);
        n = 0;
        @(negedge clock);
        while (!rd_en && n < maxc) begin
            n++;
            @(negedge clock);
        end
        chk(name, rd_en, 1);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n;
        n = 0;
        while ((busy || expq.size() != 0 || cnt != 3'd0) && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk(name, {busy, cnt, expq.size() == 0}, {1'b0, 3'd0, 1'b1});
        @(posedge clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, base;
        logic [WIDTH-1:0] v;
        int sent, guard;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", {rd_en, out_valid, out_first, out_last, busy, out_data}, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_reset_idle", {busy, out_valid, rd_en}, 0);

        // Full burst with the sink always ready
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i), i == 0, i == 3, 1'b1);
        wait_rd(10, "burst_start", n);
        for (int i = 0; i < 4; i++) begin
            chk("burst_pop_b2b", rd_en, 1);
            @(negedge clock);
            chk("burst_stream", {out_valid, out_data}, {1'b1, 8'hA0 + 8'(i)});
        end
        @(posedge clock); #1;
        wait_idle(20, "burst_drain");

        // Backpressure: only two words may be taken into the buffer
        out_ready = 1'b0;
        base = pops;
        for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i), i == 0, i == 3, 1'b1);
        repeat (6) @(posedge clock);
        #1;
        chk("bp_pop_count", pops - base, 2);
        chk("bp_head_held", {out_valid, out_first, out_data}, {1'b1, 1'b1, 8'hB0});
        out_ready = 1'b1;
        wait_idle(20, "bp_drain");

        // Idle timeout flush of a two-word partial
        wr(8'hC0, 1'b1, 1'b0, 1'b1);
        wr(8'hC1, 1'b0, 1'b1, 1'b1);
        wait_rd(40, "timeout_start", n);
        chk("timeout_idle_cycles", n, 15);
        @(posedge clock); #1;
        wait_idle(20, "timeout_drain");

        // Flush request on a three-word partial: pops begin the next cycle
        for (int i = 0; i < 3; i++) wr(8'hD0 + 8'(i), i == 0, i == 2, 1'b1);
        pulse_flush();
        @(negedge clock);
        chk("flush_pop_next", rd_en, 1);
        @(posedge clock); #1;
        wait_idle(20, "flush_drain");

        // Flush request during a stalled burst must be dropped, not queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'hE0 + 8'(i), i == 0, i == 3, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        chk("stalled_burst_busy", busy, 1);
        pulse_flush();
        wr(8'hF0, 1'b1, 1'b1, 1'b1);
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk("stalled_burst_done", {busy, cnt}, {1'b0, 3'd1});
        base = pops;
        repeat (5) @(negedge clock);
        chk("flush_not_queued", pops - base, 0);
        @(posedge clock); #1;
        wait_idle(40, "late_timeout_drain");

        // Reset after the second pop of a burst
        base = pops;
        for (int i = 0; i < 4; i++) wr(8'h50 + 8'(i), i == 0, i == 3, 1'b1);
        n = 0;
        while ((pops - base) < 2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("rst_two_pops", pops - base, 2);
        reset = 1'b1;
        #1;
        chk("rst_outputs_now", {rd_en, out_valid, out_first, out_last, busy, out_data}, 0);
        expq.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_release", {busy, out_valid, rd_en, cnt}, 0);
        @(posedge clock); #1;
        wr(8'h60, 1'b1, 1'b1, 1'b1);
        wait_rd(40, "rst_timer_start", n);
        chk("rst_timer_cleared", n, 16);
        @(posedge clock); #1;
        wait_idle(20, "rst_drain");

        // Random writes, sink stalls and flush pulses
        v = 8'h00;
        sent = 0;
        guard = 0;
        while (sent < 500 && guard < 20000) begin
            out_ready     = ($urandom_range(0, 3) != 0);
            flush_request = ($urandom_range(0, 15) == 0);
            if (cnt < 3'd4 && $urandom_range(0, 1) == 1) begin
                wr_en   = 1'b1;
                wr_data = v;
                expq.push_back(mk(v, 1'b0, 1'b0, 1'b0));
                v++;
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clock); #1;
            guard++;
        end
        wr_en         = 1'b0;
        flush_request = 1'b0;
        out_ready     = 1'b1;
        chk("random_sent", sent, 500);
        wait_idle(200, "random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
